// File: rtl/period_capture_counter.sv
// Multi-channel trigger timestamp and edge-to-edge period capture on a shared free-running counter.
// Build option: define PERIOD_CAPTURE_PERIOD_EN to compile in period subtraction and per-channel arming.
//
// Per-channel arm state (only with PERIOD_CAPTURE_PERIOD_EN):
//   state    | meaning
//   DISARMED | no reference edge yet; next event loads capture_o only
//   ARMED    | reference edge held; each event yields a period and valid_o
module period_capture_counter #(
  parameter int WIDTH       = 20,
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      fpga_clk_i,
  input  logic                      reset_n_i,
  input  logic                      clear_i,
  input  logic [CHANNELS-1:0]       trigger_i,
  input  logic [CHANNELS-1:0]       ack_i,
  output logic [WIDTH-1:0]          counter_val_o,
  output logic                      counter_cleared_o,
  output logic [CHANNELS*WIDTH-1:0] capture_o,
  output logic [CHANNELS*WIDTH-1:0] period_o,
  output logic [CHANNELS-1:0]       valid_o,
  output logic [CHANNELS-1:0]       overrun_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = clear_i ? '0 : count_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

  assign counter_val_o     = count_q;
  assign counter_cleared_o = (count_q == '0);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : gen_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   event_q;
    logic [WIDTH-1:0]       cap_q, cap_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;

    // Event is registered once more so detection-to-update latency is SYNC_STAGES+1
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        sync_q  <= '0;
        hist_q  <= 1'b0;
        event_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], trigger_i[ch]};
        hist_q  <= sync_q[SYNC_STAGES-1];
        event_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
      end
    end

`ifdef PERIOD_CAPTURE_PERIOD_EN
    localparam logic DISARMED = 1'b0;
    localparam logic ARMED    = 1'b1;

    logic             armed_q, armed_d;
    logic [WIDTH-1:0] per_q, per_d;

    always_comb begin
      cap_d   = cap_q;
      per_d   = per_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      armed_d = armed_q;
      if (ack_i[ch] && valid_q) begin
        valid_d = 1'b0;
        ovr_d   = 1'b0;
      end
      if (clear_i) begin
        armed_d = DISARMED;
      end else if (event_q) begin
        cap_d = count_q;
        if (armed_q == ARMED) begin
          per_d   = count_q - cap_q;
          valid_d = 1'b1;
          if (valid_q && !ack_i[ch]) ovr_d = 1'b1;
        end else begin
          per_d   = '0;
          armed_d = ARMED;
        end
      end
    end

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        armed_q <= DISARMED;
        per_q   <= '0;
      end else begin
        armed_q <= armed_d;
        per_q   <= per_d;
      end
    end

    assign period_o[ch*WIDTH +: WIDTH] = per_q;
`else
    always_comb begin
      cap_d   = cap_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (ack_i[ch] && valid_q) begin
        valid_d = 1'b0;
        ovr_d   = 1'b0;
      end
      if (event_q && !clear_i) begin
        cap_d   = count_q;
        valid_d = 1'b1;
        if (valid_q && !ack_i[ch]) ovr_d = 1'b1;
      end
    end

    assign period_o[ch*WIDTH +: WIDTH] = '0;
`endif

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        cap_q   <= '0;
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        cap_q   <= cap_d;
        valid_q <= valid_d;
        ovr_q   <= ovr_d;
      end
    end

    assign capture_o[ch*WIDTH +: WIDTH] = cap_q;
    assign valid_o[ch]                  = valid_q;
    assign overrun_o[ch]                = ovr_q;
  end

endmodule

// File: tb/tb_period_capture_counter.sv
// Directed bench for period_capture_counter (WIDTH=8, CHANNELS=2, SYNC_STAGES=2).
// Expectations follow PERIOD_CAPTURE_PERIOD_EN as defined for the build.
module tb_period_capture_counter;

`ifdef PERIOD_CAPTURE_PERIOD_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        fpga_clk_i = 1'b0;
  logic        reset_n_i  = 1'b0;
  logic        clear_i    = 1'b0;
  logic [1:0]  trigger_i  = 2'b00;
  logic [1:0]  ack_i      = 2'b00;
  logic [7:0]  counter_val_o;
  logic        counter_cleared_o;
  logic [15:0] capture_o;
  logic [15:0] period_o;
  logic [1:0]  valid_o;
  logic [1:0]  overrun_o;

  period_capture_counter #(.WIDTH(8), .CHANNELS(2), .SYNC_STAGES(2)) dut (
    .fpga_clk_i       (fpga_clk_i),
    .reset_n_i        (reset_n_i),
    .clear_i          (clear_i),
    .trigger_i        (trigger_i),
    .ack_i            (ack_i),
    .counter_val_o    (counter_val_o),
    .counter_cleared_o(counter_cleared_o),
    .capture_o        (capture_o),
    .period_o         (period_o),
    .valid_o          (valid_o),
    .overrun_o        (overrun_o)
  );

  always #5 fpga_clk_i = ~fpga_clk_i;

  wire [7:0] cap0 = capture_o[7:0];
  wire [7:0] cap1 = capture_o[15:8];
  wire [7:0] per0 = period_o[7:0];
  wire [7:0] per1 = period_o[15:8];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic tick();
    logic rst, clr;
    rst = reset_n_i;
    clr = clear_i;
    @(posedge fpga_clk_i);
    #1;
    if (!rst || !reset_n_i) exp_cnt = 8'd0;
    else if (clr)           exp_cnt = 8'd0;
    else                    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic ack_pulse(input int c);
    ack_i[c] = 1'b1;
    tick();
    ack_i[c] = 1'b0;
  endtask

  // Raises the trigger, optionally drives ack/clear in the detection cycle, returns the detection count
  task automatic fire(input int c, input bit ack_det, input bit clr_det, output logic [7:0] det);
    trigger_i[c] = 1'b1;
    tick(); tick(); tick();
    det = exp_cnt;
    if (ack_det) ack_i[c] = 1'b1;
    if (clr_det) clear_i = 1'b1;
    tick();
    ack_i[c]     = 1'b0;
    clear_i      = 1'b0;
    trigger_i[c] = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    tick(); tick();
    reset_n_i = 1'b1;
    tick();
    chk_cnt++;
    if (counter_val_o !== 8'd1) $display("FAIL rst_first_count: got %0d want 1", counter_val_o);
    else pass_cnt++;
    fire(0, 1'b0, 1'b0, d);
    chk_cnt++;
    if (cap0 !== d) $display("FAIL rst_pre_capture: got %0d want %0d", cap0, d);
    else pass_cnt++;
    #3 reset_n_i = 1'b0;
    #1;
    chk_cnt++;
    if (counter_val_o !== 8'd0 || counter_cleared_o !== 1'b1)
      $display("FAIL rst_counter: got cnt=%0d clr=%b want 0/1", counter_val_o, counter_cleared_o);
    else pass_cnt++;
    chk_cnt++;
    if (capture_o !== 16'd0 || period_o !== 16'd0 || valid_o !== 2'b00 || overrun_o !== 2'b00)
      $display("FAIL rst_outputs: got cap=%h per=%h v=%b o=%b want 0", capture_o, period_o, valid_o, overrun_o);
    else pass_cnt++;
    tick();
    reset_n_i = 1'b1;
    tick();
    chk_cnt++;
    if (counter_val_o !== 8'd1) $display("FAIL rst_release_count: got %0d want 1", counter_val_o);
    else pass_cnt++;
  endtask

  logic [7:0] d1, d2, d3;

  task automatic test_period();
    fire(0, 1'b0, 1'b0, d1);
    chk_cnt++;
    if (valid_o[0] !== !PEN || cap0 !== d1 || per0 !== 8'd0)
      $display("FAIL p_first_edge: got v=%b cap=%0d per=%0d want v=%b cap=%0d per=0", valid_o[0], cap0, per0, !PEN, d1);
    else pass_cnt++;
    ack_pulse(0);
    wait_n(95);
    trigger_i[0] = 1'b1;
    tick(); tick(); tick();
    d2 = exp_cnt;
    chk_cnt++;
    if (valid_o[0] !== 1'b0) $display("FAIL p_latency_early: got v=%b want 0", valid_o[0]);
    else pass_cnt++;
    tick();
    trigger_i[0] = 1'b0;
    chk_cnt++;
    if (valid_o[0] !== 1'b1) $display("FAIL p_latency_valid: got v=%b want 1", valid_o[0]);
    else pass_cnt++;
    chk_cnt++;
    if (per0 !== (PEN ? 8'd100 : 8'd0)) $display("FAIL p_period100: got %0d want %0d", per0, PEN ? 100 : 0);
    else pass_cnt++;
    chk_cnt++;
    if (cap0 !== d2) $display("FAIL p_capture: got %0d want %0d", cap0, d2);
    else pass_cnt++;
    ack_pulse(0);
    chk_cnt++;
    if (valid_o[0] !== 1'b0 || overrun_o[0] !== 1'b0)
      $display("FAIL p_ack: got v=%b o=%b want 0/0", valid_o[0], overrun_o[0]);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    while (exp_cnt != 8'd247 && guard < 300) begin
      tick();
      guard++;
    end
    fire(0, 1'b0, 1'b0, d3);
    chk_cnt++;
    if (cap0 !== 8'd250 || per0 !== (PEN ? 8'(8'd250 - d2) : 8'd0))
      $display("FAIL w_first: got cap=%0d per=%0d want cap=250 per=%0d", cap0, per0, PEN ? 8'(8'd250 - d2) : 8'd0);
    else pass_cnt++;
    ack_pulse(0);
    wait_n(15);
    fire(0, 1'b0, 1'b0, d3);
    chk_cnt++;
    if (cap0 !== 8'd14 || per0 !== (PEN ? 8'd20 : 8'd0) || valid_o[0] !== 1'b1)
      $display("FAIL w_wrap: got cap=%0d per=%0d v=%b want cap=14 per=%0d v=1", cap0, per0, valid_o[0], PEN ? 20 : 0);
    else pass_cnt++;
    ack_pulse(0);
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    fire(1, 1'b0, 1'b0, e);
    wait_n(26);
    fire(1, 1'b0, 1'b0, e);
    chk_cnt++;
    if (valid_o[1] !== 1'b1 || overrun_o[1] !== !PEN || per1 !== (PEN ? 8'd30 : 8'd0))
      $display("FAIL o_second: got v=%b o=%b per=%0d want v=1 o=%b per=%0d", valid_o[1], overrun_o[1], per1, !PEN, PEN ? 30 : 0);
    else pass_cnt++;
    wait_n(26);
    fire(1, 1'b0, 1'b0, e);
    chk_cnt++;
    if (overrun_o[1] !== 1'b1 || valid_o[1] !== 1'b1) $display("FAIL o_flag: got o=%b v=%b want 1/1", overrun_o[1], valid_o[1]);
    else pass_cnt++;
    chk_cnt++;
    if (cap1 !== e || per1 !== (PEN ? 8'd30 : 8'd0))
      $display("FAIL o_newest: got cap=%0d per=%0d want cap=%0d per=%0d", cap1, per1, e, PEN ? 30 : 0);
    else pass_cnt++;
    chk_cnt++;
    if (valid_o[0] !== 1'b0 || overrun_o[0] !== 1'b0 || cap0 !== 8'd14)
      $display("FAIL o_ch0_indep: got v=%b o=%b cap=%0d want 0/0/14", valid_o[0], overrun_o[0], cap0);
    else pass_cnt++;
    ack_pulse(1);
    chk_cnt++;
    if (valid_o[1] !== 1'b0 || overrun_o[1] !== 1'b0)
      $display("FAIL o_ack_clear: got v=%b o=%b want 0/0", valid_o[1], overrun_o[1]);
    else pass_cnt++;
  endtask

  logic [7:0] fb;

  task automatic test_back_to_back();
    logic [7:0] fa;
    fire(0, 1'b0, 1'b0, fa);
    chk_cnt++;
    if (valid_o[0] !== 1'b1 || cap0 !== fa) $display("FAIL b_pending: got v=%b cap=%0d want 1/%0d", valid_o[0], cap0, fa);
    else pass_cnt++;
    wait_n(16);
    fire(0, 1'b1, 1'b0, fb);
    chk_cnt++;
    if (valid_o[0] !== 1'b1 || overrun_o[0] !== 1'b0)
      $display("FAIL b_event_ack: got v=%b o=%b want 1/0", valid_o[0], overrun_o[0]);
    else pass_cnt++;
    chk_cnt++;
    if (cap0 !== fb || per0 !== (PEN ? 8'd20 : 8'd0))
      $display("FAIL b_new_data: got cap=%0d per=%0d want cap=%0d per=%0d", cap0, per0, fb, PEN ? 20 : 0);
    else pass_cnt++;
    ack_pulse(0);
  endtask

  task automatic test_clear();
    logic [7:0] fc, fd, fe;
    wait_n(10);
    fire(0, 1'b0, 1'b1, fc);
    chk_cnt++;
    if (counter_val_o !== 8'd0 || counter_cleared_o !== 1'b1)
      $display("FAIL c_counter: got cnt=%0d clr=%b want 0/1", counter_val_o, counter_cleared_o);
    else pass_cnt++;
    chk_cnt++;
    if (cap0 !== fb || per0 !== (PEN ? 8'd20 : 8'd0) || valid_o[0] !== 1'b0)
      $display("FAIL c_dropped: got cap=%0d per=%0d v=%b want cap=%0d per=%0d v=0", cap0, per0, valid_o[0], fb, PEN ? 20 : 0);
    else pass_cnt++;
    wait_n(6);
    fire(0, 1'b0, 1'b0, fd);
    chk_cnt++;
    if (valid_o[0] !== !PEN || cap0 !== fd || per0 !== 8'd0)
      $display("FAIL c_rearm: got v=%b cap=%0d per=%0d want v=%b cap=%0d per=0", valid_o[0], cap0, per0, !PEN, fd);
    else pass_cnt++;
    ack_pulse(0);
    wait_n(20);
    fire(0, 1'b0, 1'b0, fe);
    chk_cnt++;
    if (valid_o[0] !== 1'b1 || cap0 !== fe || per0 !== (PEN ? 8'd25 : 8'd0))
      $display("FAIL c_after_arm: got v=%b cap=%0d per=%0d want v=1 cap=%0d per=%0d", valid_o[0], cap0, per0, fe, PEN ? 25 : 0);
    else pass_cnt++;
    chk_cnt++;
    if (counter_val_o !== exp_cnt) $display("FAIL c_count_track: got %0d want %0d", counter_val_o, exp_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_period();
    test_wrap();
    test_overrun();
    test_back_to_back();
    test_clear();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/period_capture_counter.md
# period_capture_counter

Multi-channel, parametrised successor to the single-trigger save counter in the ADPLL measurement path. A free-running `fpga_clk_i` counter is shared by `CHANNELS` asynchronous trigger inputs (reference and DCO-derived clocks). Each channel synchronises its trigger, timestamps rising edges and computes the edge-to-edge period. Results go out through a per-channel valid/ack handshake with overrun detection, for consumption by the loop filter and phase-detector logic.

## Interface

Parameters:
- `WIDTH`, default 20: counter, capture and period width in bits.
- `CHANNELS`, default 2: number of independent trigger channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser flops per trigger (≥2).

Ports:
- `fpga_clk_i`  in  1  system clock; all logic on its rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `clear_i`  in  1  synchronous counter clear; also disarms all channels.
- `trigger_i`  in  CHANNELS  asynchronous trigger inputs, one bit per channel.
- `ack_i`  in  CHANNELS  per-channel result acknowledge.
- `counter_val_o`  out  WIDTH  current free-running count.
- `counter_cleared_o`  out  1  high when `counter_val_o == 0`.
- `capture_o`  out  CHANNELS*WIDTH  last timestamp; channel c at bits [c*WIDTH +: WIDTH].
- `period_o`  out  CHANNELS*WIDTH  last edge-to-edge period, packed the same way.
- `valid_o`  out  CHANNELS  result pending.
- `overrun_o`  out  CHANNELS  sticky: a pending result was overwritten.

## Operation

- **Reset** (`reset_n_i`=0, takes effect immediately):
  - Counter, all synchroniser/edge flops, `capture_o`, `period_o`, `valid_o`, `overrun_o` and the arm flags are cleared to 0.
  - `counter_cleared_o` = 1.
- **Counter:**
  - Increments by 1 every cycle and wraps from 2^WIDTH−1 to 0.
  - `clear_i`=1 loads 0 on the next edge; clear has priority over increment.
  - `counter_cleared_o` is combinational from the counter register.
- **Per-channel edge detection:**
  - `trigger_i[c]` passes through `SYNC_STAGES` flops plus one history flop.
  - An event is a synchronised 0→1 transition. Falling edges are ignored.
- **Per-channel state:**
  - DISARMED → ARMED on the first event after reset or clear. That event loads `capture_o` and sets `period_o`=0; `valid_o` is not asserted.
  - In ARMED, each event does the following:
    - `period_o` ← (counter − `capture_o`) mod 2^WIDTH, so wrap-around is handled by modular subtraction.
    - `capture_o` ← counter.
    - `valid_o` ← 1.
- **Handshake:**
  - `valid_o[c]` holds until a cycle with `ack_i[c]`=1 and `valid_o[c]`=1; it clears on the next edge.
  - `ack_i` while `valid_o`=0 is ignored.
  - Event and ack in the same cycle: new data loads, `valid_o` stays 1, no overrun.
  - Event while `valid_o`=1 and no ack: data is overwritten (newest wins) and `overrun_o[c]` ← 1. `overrun_o` clears only on an accepted ack.
- **`clear_i` coinciding with an event:**
  - The event is discarded and the channel goes to DISARMED.
  - `capture_o` and `period_o` are unchanged.
  - `valid_o` and `overrun_o` are unchanged, so pending data stays readable.
- Channels are fully independent. Simultaneous events on several channels all capture the same counter value.

## Timing

- A `trigger_i` rise sampled at clock edge k is detected as an event in the cycle after edge k+SYNC_STAGES.
  - `capture_o`, `period_o` and `valid_o` update at edge k+SYNC_STAGES+1.
  - Total latency: SYNC_STAGES+1 cycles.
- Latency is constant, so periods are exact cycle counts between synchronised edges, with ±1 cycle of synchroniser jitter per edge.
- Trigger high and low phases must each be ≥2 cycles to guarantee detection. Shorter pulses may be missed.
- All outputs are registered except `counter_cleared_o`.

## Configuration

- `PERIOD_CAPTURE_PERIOD_EN` defined:
  - Period subtraction and the DISARMED/ARMED arming are compiled in, as described above.
- Not defined:
  - No subtractor and no arm flags.
  - `period_o` is tied to 0.
  - Every event, including the first after reset or clear, loads `capture_o` and asserts `valid_o`. Handshake and overrun rules are unchanged.

## Test plan

Bench configuration: WIDTH=8, CHANNELS=2, SYNC_STAGES=2, macro defined unless stated.

1. Assert `reset_n_i`=0 mid-count → all outputs 0 and `counter_cleared_o`=1 immediately. Release → counter reads 1 after the first edge.
2. ch0 rising edges 100 cycles apart, ack each result → first edge gives no `valid_o`; second gives `valid_o`=1, `period_o`=100, `capture_o`=`counter_val_o` at detection; `valid_o` appears 3 cycles after the edge.
3. Wrap: edges detected at counter 250 and 270 (mod 256) → `capture_o`=14, `period_o`=20.
4. ch1 three events 30 cycles apart with no ack → `overrun_o[1]`=1, `capture_o`/`period_o` hold the third event's data, and ch0 is unaffected. Then one ack → `valid_o[1]`=0 and `overrun_o[1]`=0.
5. Event and `ack_i` in the same cycle with `valid_o`=1 → `valid_o` stays 1, new period loaded, `overrun_o`=0. Separately, `clear_i` coincident with an event → event dropped, counter 0, next event arms without valid.
6. Macro undefined, same stimulus as 2 → `valid_o` on the first edge, `period_o`=0 throughout.
